// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op/state encodings and result record shared by alu_pipe
package alu_pkg;

  // Widest operand any alu_pipe instance may use; the result record is sized for it.
  localparam int ALU_WMAX = 64;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_NOTA = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NAND = 4'b0101,
    OP_ADD  = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_MULU = 4'b1100
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ALU_WMAX-1:0] y;
    logic                cout;
    logic                negative;
    logic                zero;
    logic                overflow;
  } result_t;

  // Builds a w-bit-wide result: y is masked to w bits, negative/zero derived from that slice.
  function automatic result_t make_result(input logic [ALU_WMAX-1:0] y, input int unsigned w,
                                          input logic cout, input logic overflow);
    result_t             r;
    logic [ALU_WMAX-1:0] m;
    m          = {ALU_WMAX{1'b1}} >> (ALU_WMAX - w);
    r.y        = y & m;
    r.cout     = cout;
    r.negative = |(r.y & (m ^ (m >> 1)));
    r.zero     = (r.y == '0);
    r.overflow = overflow;
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - W-cycle shift-add unsigned multiplier, one multiplier bit per step
module alu_mul_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int SHW = $clog2(W);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [SHW-1:0] r_cnt;
  logic [2*W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // o_product is the accumulator after the current step, so on the last
  // step the caller can register the full product at the same edge.
  assign o_done    = (r_cnt == SHW'(W - 1));
  assign o_product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with single-cycle ops and iterative multiply
module alu_pipe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         negative,
  output logic         zero,
  output logic         overflow,
  output logic         busy
);

  import alu_pkg::*;

  localparam int SHW = $clog2(W);

  state_e         r_state;
  logic           r_busy;
  logic           r_out_valid;
  result_t        r_res;

  result_t        w_comb_res;
  result_t        w_mul_res;
  logic [W-1:0]   w_b_eff;
  logic [W-1:0]   w_y;
  logic [W:0]     w_sum;
  logic [SHW-1:0] w_shamt;
  logic           w_cout;
  logic           w_ovf;
  logic           w_out_free;
  logic           w_in_fire;
  logic           w_is_mul;
  logic           w_mul_done;
  logic           w_mul_step;
  logic [2*W-1:0] w_mul_prod;
  logic           w_unused;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = rst_n && (r_state == S_IDLE) && w_out_free;
  assign w_in_fire  = in_valid && in_ready;
  assign w_is_mul   = (sel == OP_MULU);

  assign w_shamt = b[SHW-1:0];
  assign w_b_eff = (sel == OP_SUB) ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, cin};

  always_comb begin
    w_y    = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (op_e'(sel))
      OP_AND:  w_y = a & b;
      OP_OR:   w_y = a | b;
      OP_NOTA: w_y = ~a;
      OP_NOR:  w_y = ~(a | b);
      OP_XOR:  w_y = a ^ b;
      OP_NAND: w_y = ~(a & b);
      OP_ADD, OP_SUB: begin
        w_y    = w_sum[W-1:0];
        w_cout = w_sum[W];
        w_ovf  = (a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SLT:  w_y[0] = $signed(a) < $signed(b);
      OP_SLL:  w_y = a << w_shamt;
      OP_SRL:  w_y = a >> w_shamt;
      OP_SRA:  w_y = $signed(a) >>> w_shamt;
      default: w_y = '0;
    endcase
  end

  assign w_comb_res = make_result(ALU_WMAX'(w_y), W, w_cout, w_ovf);
  assign w_mul_res  = make_result(ALU_WMAX'(w_mul_prod[W-1:0]), W, 1'b0, |w_mul_prod[2*W-1:W]);

  // The last iteration is held until the output slot is free, so a pending
  // result is never overwritten.
  assign w_mul_step = (r_state == S_MUL) && (!w_mul_done || w_out_free);

  alu_mul_iter #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_in_fire && w_is_mul),
    .i_step    (w_mul_step),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            if (w_is_mul) begin
              r_state     <= S_MUL;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_res       <= w_comb_res;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (w_mul_done && w_out_free) begin
            r_res       <= w_mul_res;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign y         = r_res.y[W-1:0];
  assign cout      = r_res.cout;
  assign negative  = r_res.negative;
  assign zero      = r_res.zero;
  assign overflow  = r_res.overflow;
  assign w_unused  = ^r_res.y;

endmodule
